// File: rtl/digital_clock_cfg.sv
// BCD HH:MM:SS timekeeper with 12/24-hour display, set mode, minute alarm and a
// multiplexed common-anode 7-segment driver; the 1 Hz tick is an enable, not a clock.
module digital_clock_cfg #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned SCAN_N = 18,
    parameter int unsigned BLINK  = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       mode_12h,
    input  logic       set_en,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    input  logic       alarm_on,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] an,
    output logic       pm,
    output logic       tick,
    output logic       alarm
);

    localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [SCAN_N-1:0] SCAN_ONE = SCAN_N'(1);
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic [0:0] {StRun, StSet} state_e;

    state_e            r_state, w_state_nxt;
    logic [PW-1:0]     r_presc, w_presc_nxt;
    logic [SCAN_N-1:0] r_scan;
    logic              r_tick, w_tick_nxt;
    logic              r_alarm, w_alarm_nxt;
    logic [3:0]        r_sec_l, r_sec_m, r_min_l, r_min_m, r_hr_l, r_hr_m;
    logic [3:0]        w_sec_l_nxt, w_sec_m_nxt, w_min_l_nxt, w_min_m_nxt;
    logic [3:0]        w_hr_l_nxt, w_hr_m_nxt;

    logic              w_run, w_in_set, w_adv;
    logic              w_sec_wrap, w_min_wrap, w_hr_wrap, w_inc_m, w_inc_h;
    logic [4:0]        w_hr_bin_nxt;
    logic [5:0]        w_min_bin_nxt;

    logic [4:0]        w_hr_bin, w_hr12;
    logic [3:0]        w_dig_hm, w_dig_hl, w_digit;
    logic [2:0]        w_slot;
    logic              w_colon;

    // Counting happens only in RUN with set_en low; any SET request freezes and clears.
    assign w_run    = (r_state == StRun) && !set_en;
    assign w_in_set = (r_state == StSet);
    assign w_adv    = r_tick && w_run;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StRun:   if (set_en)  w_state_nxt = StSet;
            StSet:   if (!set_en) w_state_nxt = StRun;
            default: w_state_nxt = StRun;
        endcase
        w_presc_nxt = '0;
        w_tick_nxt  = 1'b0;
        if (w_run) begin
            w_presc_nxt = (r_presc == PRESC_MAX) ? '0 : r_presc + PRESC_ONE;
            w_tick_nxt  = (r_presc == PRESC_MAX);
        end
    end

    always_comb begin
        w_sec_l_nxt = r_sec_l;
        w_sec_m_nxt = r_sec_m;
        w_min_l_nxt = r_min_l;
        w_min_m_nxt = r_min_m;
        w_hr_l_nxt  = r_hr_l;
        w_hr_m_nxt  = r_hr_m;
        w_sec_wrap  = (r_sec_l == 4'd9) && (r_sec_m == 4'd5);
        w_min_wrap  = (r_min_l == 4'd9) && (r_min_m == 4'd5);
        w_hr_wrap   = (r_hr_l == 4'd3) && (r_hr_m == 4'd2);
        w_inc_m     = (w_adv && w_sec_wrap) || (w_in_set && inc_min);
        w_inc_h     = (w_adv && w_sec_wrap && w_min_wrap) || (w_in_set && inc_hour);

        if (!w_run) begin
            w_sec_l_nxt = 4'd0;
            w_sec_m_nxt = 4'd0;
        end else if (w_adv) begin
            if (r_sec_l == 4'd9) begin
                w_sec_l_nxt = 4'd0;
                w_sec_m_nxt = (r_sec_m == 4'd5) ? 4'd0 : r_sec_m + 4'd1;
            end else begin
                w_sec_l_nxt = r_sec_l + 4'd1;
            end
        end

        if (w_inc_m) begin
            if (r_min_l == 4'd9) begin
                w_min_l_nxt = 4'd0;
                w_min_m_nxt = (r_min_m == 4'd5) ? 4'd0 : r_min_m + 4'd1;
            end else begin
                w_min_l_nxt = r_min_l + 4'd1;
            end
        end

        if (w_inc_h) begin
            if (w_hr_wrap) begin
                w_hr_l_nxt = 4'd0;
                w_hr_m_nxt = 4'd0;
            end else if (r_hr_l == 4'd9) begin
                w_hr_l_nxt = 4'd0;
                w_hr_m_nxt = r_hr_m + 4'd1;
            end else begin
                w_hr_l_nxt = r_hr_l + 4'd1;
            end
        end

        // Alarm compares in binary so out-of-range alarm settings can never match.
        w_hr_bin_nxt  = 5'(w_hr_m_nxt) * 5'd10 + 5'(w_hr_l_nxt);
        w_min_bin_nxt = 6'(w_min_m_nxt) * 6'd10 + 6'(w_min_l_nxt);
        w_alarm_nxt   = w_adv && alarm_on && (w_sec_l_nxt == 4'd0) && (w_sec_m_nxt == 4'd0) &&
                        (w_hr_bin_nxt == alarm_hh) && (w_min_bin_nxt == alarm_mm);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StRun;
            r_presc <= '0;
            r_scan  <= '0;
            r_tick  <= 1'b0;
            r_alarm <= 1'b0;
            r_sec_l <= 4'd0;
            r_sec_m <= 4'd0;
            r_min_l <= 4'd0;
            r_min_m <= 4'd0;
            r_hr_l  <= 4'd0;
            r_hr_m  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_scan  <= r_scan + SCAN_ONE;
            r_tick  <= w_tick_nxt;
            r_alarm <= w_alarm_nxt;
            r_sec_l <= w_sec_l_nxt;
            r_sec_m <= w_sec_m_nxt;
            r_min_l <= w_min_l_nxt;
            r_min_m <= w_min_m_nxt;
            r_hr_l  <= w_hr_l_nxt;
            r_hr_m  <= w_hr_m_nxt;
        end
    end

    always_comb begin
        w_hr_bin = 5'(r_hr_m) * 5'd10 + 5'(r_hr_l);
        if (w_hr_bin == 5'd0) begin
            w_hr12 = 5'd12;
        end else if (w_hr_bin > 5'd12) begin
            w_hr12 = w_hr_bin - 5'd12;
        end else begin
            w_hr12 = w_hr_bin;
        end
        if (mode_12h) begin
            w_dig_hm = (w_hr12 >= 5'd10) ? 4'd1 : BLANK;
            w_dig_hl = (w_hr12 >= 5'd10) ? 4'(w_hr12 - 5'd10) : w_hr12[3:0];
        end else begin
            w_dig_hm = r_hr_m;
            w_dig_hl = r_hr_l;
        end
    end

    assign w_slot  = r_scan[SCAN_N-1 -: 3];
    assign w_colon = (BLINK == 0) || (r_presc < PRESC_HALF) || (r_state == StSet);

    always_comb begin
        w_digit = BLANK;
        an      = 8'hFF;
        dp      = 1'b1;
        case (w_slot)
            3'd0: begin w_digit = r_sec_l;  an = 8'b1111_1110; end
            3'd1: begin w_digit = r_sec_m;  an = 8'b1111_1101; end
            3'd2: begin w_digit = r_min_l;  an = 8'b1111_1011; dp = !w_colon; end
            3'd3: begin w_digit = r_min_m;  an = 8'b1111_0111; end
            3'd4: begin w_digit = w_dig_hl; an = 8'b1110_1111; dp = !w_colon; end
            3'd5: begin w_digit = w_dig_hm; an = 8'b1101_1111; end
            default: begin w_digit = BLANK; an = 8'hFF; end
        endcase
    end

    always_comb begin
        case (w_digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'h7F;
        endcase
    end

    assign pm    = (w_hr_bin >= 5'd12);
    assign tick  = r_tick;
    assign alarm = r_alarm;

endmodule

// File: tb/tb_digital_clock_cfg.sv
// Bench for digital_clock_cfg: seconds-of-day reference model, tick/alarm scoreboard
// queues, per-cycle display monitor and directed set/alarm/12h scenarios.
module tb_digital_clock_cfg;

    localparam int CLK  = 10;
    localparam int SCAN = 6;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode_12h = 1'b0;
    logic       set_en = 1'b0;
    logic       inc_hour = 1'b0;
    logic       inc_min = 1'b0;
    logic [4:0] alarm_hh = 5'd0;
    logic [5:0] alarm_mm = 6'd1;
    logic       alarm_on = 1'b1;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic       pm;
    logic       tick;
    logic       alarm;

    digital_clock_cfg #(.CLK_HZ(CLK), .SCAN_N(SCAN), .BLINK(1)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .mode_12h (mode_12h),
        .set_en   (set_en),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .alarm_hh (alarm_hh),
        .alarm_mm (alarm_mm),
        .alarm_on (alarm_on),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .pm       (pm),
        .tick     (tick),
        .alarm    (alarm)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;
    int alarm_seen = 0;
    bit mon_en = 1'b0;

    // Reference model state: time as seconds of day
    int m_t = 0;
    int m_phase = 0;
    int m_scan = 0;
    int cyc = 0;
    bit m_set = 1'b0;
    bit m_tick = 1'b0;
    int tick_q[$];
    int alarm_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Returns {an, seg, dp, pm}
    function automatic logic [16:0] exp_disp(input int t, input bit m12, input int slot,
                                             input int phase, input bit st_set);
        int h, mi, s, hd, d;
        logic [7:0] a;
        logic dpv;
        h  = t / 3600;
        mi = (t / 60) % 60;
        s  = t % 60;
        hd = m12 ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
        case (slot)
            0: d = s % 10;
            1: d = s / 10;
            2: d = mi % 10;
            3: d = mi / 10;
            4: d = hd % 10;
            5: d = (m12 && hd < 10) ? -1 : hd / 10;
            default: d = -1;
        endcase
        a = (slot < 6) ? ~(8'b1 << slot) : 8'hFF;
        dpv = 1'b1;
        if ((slot == 2 || slot == 4) && (phase < CLK / 2 || st_set)) dpv = 1'b0;
        return {a, seg_of(d), dpv, (h >= 12)};
    endfunction

    // Reference model: advances on each clock edge from the sampled inputs
    initial begin
        bit adv, running, new_tick;
        int hh, mm;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_t = 0; m_phase = 0; m_scan = 0; m_set = 1'b0; m_tick = 1'b0;
                tick_q.delete();
                alarm_q.delete();
            end else begin
                cyc++;
                running  = !m_set && !set_en;
                adv      = m_tick && running;
                new_tick = running && (m_phase == CLK - 1);
                m_phase  = running ? (m_phase + 1) % CLK : 0;
                if (!running) m_t = m_t - (m_t % 60);
                if (m_set) begin
                    hh = m_t / 3600;
                    mm = (m_t / 60) % 60;
                    if (inc_min) mm = (mm + 1) % 60;
                    if (inc_hour) hh = (hh + 1) % 24;
                    m_t = hh * 3600 + mm * 60;
                end
                if (adv) begin
                    m_t = (m_t + 1) % 86400;
                    if (alarm_on && alarm_hh <= 23 && alarm_mm <= 59 &&
                        m_t == int'(alarm_hh) * 3600 + int'(alarm_mm) * 60)
                        alarm_q.push_back(cyc);
                end
                m_tick = new_tick;
                if (new_tick) tick_q.push_back(cyc);
                m_set  = set_en;
                m_scan = (m_scan + 1) % (1 << SCAN);
            end
        end
    end

    // Monitor: display every cycle, tick/alarm popped from the scoreboard queues
    initial begin
        logic [16:0] e;
        bit ex;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                e = exp_disp(m_t, mode_12h, (m_scan >> (SCAN - 3)) & 7, m_phase, m_set);
                chk("display", {15'b0, an, seg, dp, pm}, {15'b0, e});
                ex = (tick_q.size() > 0) && (tick_q[0] == cyc);
                if (ex) void'(tick_q.pop_front());
                if (tick || ex) chk("tick", {31'b0, tick}, {31'b0, ex});
                ex = (alarm_q.size() > 0) && (alarm_q[0] == cyc);
                if (ex) void'(alarm_q.pop_front());
                if (alarm || ex) chk("alarm", {31'b0, alarm}, {31'b0, ex});
                if (alarm) alarm_seen++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse(input bit h, input bit m);
        inc_hour = h;
        inc_min  = m;
        step(1);
        inc_hour = 1'b0;
        inc_min  = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        forever begin
            @(negedge clock);
            if (tick === 1'b1) break;
            n++;
            if (n > 4 * CLK) begin
                chk("tick_timeout", {31'b0, tick}, 32'd1);
                break;
            end
        end
        step(1);
    endtask

    // Observe one full scan of a frozen display and compare each digit position
    task automatic check_shown(input int h, input int mi, input int s, input bit m12);
        bit seen[6];
        logic [16:0] v;
        int t;
        t = h * 3600 + mi * 60 + s;
        for (int k = 0; k < 6; k++) seen[k] = 1'b0;
        repeat (1 << SCAN) begin
            @(negedge clock);
            for (int k = 0; k < 6; k++) begin
                if (!seen[k] && an == ~(8'b1 << k)) begin
                    seen[k] = 1'b1;
                    v = exp_disp(t, m12, k, 0, 1'b1);
                    chk($sformatf("shown_%0d_%0d_%0d_slot%0d", h, mi, s, k), {25'b0, seg},
                        {25'b0, v[8:2]});
                end
            end
        end
        for (int k = 0; k < 6; k++) chk($sformatf("slot_seen%0d", k), {31'b0, seen[k]}, 32'd1);
        step(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_seg"}, {25'b0, seg}, 32'h40);
        chk({tag, "_an"}, {24'b0, an}, 32'hFE);
        chk({tag, "_dp"}, {31'b0, dp}, 32'd1);
        chk({tag, "_pm"}, {31'b0, pm}, 32'd0);
        chk({tag, "_tick"}, {31'b0, tick}, 32'd0);
        chk({tag, "_alarm"}, {31'b0, alarm}, 32'd0);
    endtask

    initial begin
        int n;
        step(3);
        mon_en = 1'b1;
        @(negedge clock);
        check_reset_outputs("reset");
        step(1);
        reset_n = 1'b1;

        // 600 seconds from reset with alarm at 00:01 armed; RUN pulses must be ignored
        for (int i = 0; i < 600; i++) begin
            wait_tick(n);
            if (i == 0) chk("first_tick_after_reset", n, CLK);
            mode_12h = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        mode_12h = 1'b0;
        chk("alarm_count_armed", alarm_seen, 1);
        set_en = 1'b1;
        step(2);
        check_shown(0, 10, 0, 1'b0);

        // SET edits
        alarm_on = 1'b0;
        alarm_mm = 6'd0;
        repeat (23) pulse(1'b1, 1'b0);
        repeat (49) pulse(1'b0, 1'b1);
        check_shown(23, 59, 0, 1'b0);
        pulse(1'b0, 1'b1);
        check_shown(23, 0, 0, 1'b0);
        repeat (59) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        check_shown(0, 0, 0, 1'b0);
        mode_12h = 1'b1;
        check_shown(0, 0, 0, 1'b1);
        chk("pm_12h_midnight", {31'b0, pm}, 32'd0);
        mode_12h = 1'b0;

        // 23:59 then run across midnight with the alarm disabled
        repeat (23) pulse(1'b1, 1'b0);
        repeat (59) pulse(1'b0, 1'b1);
        set_en = 1'b0;
        wait_tick(n);
        chk("first_tick_after_set", n, CLK + 1);
        repeat (58) wait_tick(n);
        chk("pm_at_235959", {31'b0, pm}, 32'd1);
        wait_tick(n);
        chk("pm_after_wrap", {31'b0, pm}, 32'd0);
        chk("alarm_count_disabled", alarm_seen, 1);

        repeat (3) pulse(1'b1, 1'b1);
        set_en = 1'b1;
        step(2);
        check_shown(0, 0, 0, 1'b0);

        // 13:05 in both display modes
        repeat (13) pulse(1'b1, 1'b0);
        repeat (5) pulse(1'b0, 1'b1);
        mode_12h = 1'b1;
        check_shown(13, 5, 0, 1'b1);
        chk("pm_1305", {31'b0, pm}, 32'd1);
        mode_12h = 1'b0;
        check_shown(13, 5, 0, 1'b0);

        // Asynchronous reset in the middle of a cycle
        set_en = 1'b0;
        step($urandom_range(20, 40));
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        step(2);
        reset_n = 1'b1;

        // Randomised mix of set/run, edits, mode and alarm settings
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) set_en = ~set_en;
            inc_hour = ($urandom_range(0, 15) == 0);
            inc_min  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) mode_12h = ~mode_12h;
            if ($urandom_range(0, 199) == 0) begin
                alarm_on = 1'($urandom_range(0, 1));
                alarm_hh = 5'($urandom_range(0, 2));
                alarm_mm = 6'($urandom_range(0, 3));
            end
            step(1);
        end
        inc_hour = 1'b0;
        inc_min  = 1'b0;
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
